// File: rtl/audio_controller_i2c.sv
// audio_controller_i2c: write-only I2C master that programs WM8731 codec registers.
// Each accepted 24-bit command becomes START, three bytes MSB first, STOP.
// Optional build macro AUDIO_I2C_RETRY_EN: a NACKed transaction is retried
// (STOP then a fresh START) up to MAX_RETRY more times before flagging an error.
// Handshake: a command is taken on any clk edge where i_i2c_ctrl_write=1 and
// o_i2c_idle=1; strobes while busy are dropped, nothing is queued.
module audio_controller_i2c #(
    parameter int QTR_DIV   = 125,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] i_i2c_ctrl_data,
    input  logic        i_i2c_ctrl_write,
    output logic        o_i2c_idle,
    output logic        o_i2c_ack_error,
    output logic        o_scl,
    output logic        o_sda_oe,
    input  logic        i_sda,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BYTE  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    localparam logic [9:0] QMAX = 10'(QTR_DIV - 1);

    state_e      state_q, state_d;
    logic [9:0]  qcnt_q, qcnt_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] shreg_q, shreg_d;
    logic        nack_q, nack_d;
    logic        err_q, err_d;
    logic        accept, tick, phase_end, can_retry;

`ifdef AUDIO_I2C_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
    logic [23:0]   word_q, word_d;
    logic          pend_q, pend_d;
    assign can_retry = (retry_q < RMAX);
`else
    // Never retries; the comparison folds to a constant 0.
    assign can_retry = (MAX_RETRY < 0);
`endif

    assign accept    = (state_q == S_IDLE) && i_i2c_ctrl_write;
    assign tick      = (state_q != S_IDLE) && (qcnt_q == QMAX);
    assign phase_end = tick && (quarter_q == 2'd3);

    // Next-state logic: quarter timer, bit/byte counters and transaction sequencing.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        nack_d    = nack_q;
        err_d     = err_q;
`ifdef AUDIO_I2C_RETRY_EN
        retry_d   = retry_q;
        word_d    = word_q;
        pend_d    = pend_q;
`endif
        if (state_q != S_IDLE) begin
            qcnt_d = tick ? 10'd0 : qcnt_q + 10'd1;
            if (tick) quarter_d = quarter_q + 2'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    qcnt_d    = 10'd0;
                    quarter_d = 2'd0;
                    bit_d     = 3'd0;
                    byte_d    = 2'd0;
                    shreg_d   = i_i2c_ctrl_data;
                    nack_d    = 1'b0;
                    err_d     = 1'b0;
`ifdef AUDIO_I2C_RETRY_EN
                    retry_d   = '0;
                    word_d    = i_i2c_ctrl_data;
                    pend_d    = 1'b0;
`endif
                end
            end
            S_START: begin
                if (phase_end) state_d = S_BYTE;
            end
            S_BYTE: begin
                if (phase_end) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_ACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ACK: begin
                // Sample the slave's answer at the end of q2, while SCL is high.
                if (tick && (quarter_q == 2'd2)) nack_d = i_sda;
                if (phase_end) begin
                    if (nack_q) begin
                        state_d = S_STOP;
                        if (!can_retry) err_d = 1'b1;
`ifdef AUDIO_I2C_RETRY_EN
                        else pend_d = 1'b1;
`endif
                    end else if (byte_q == 2'd2) begin
                        state_d = S_STOP;
                        byte_d  = 2'd0;
                    end else begin
                        state_d = S_BYTE;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            S_STOP: begin
                if (phase_end) begin
                    state_d = S_IDLE;
`ifdef AUDIO_I2C_RETRY_EN
                    if (pend_q) begin
                        state_d = S_START;
                        pend_d  = 1'b0;
                        retry_d = retry_q + RW'(1);
                        shreg_d = word_q;
                        bit_d   = 3'd0;
                        byte_d  = 2'd0;
                        nack_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous abort to IDLE (no STOP is generated).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            qcnt_q    <= 10'd0;
            quarter_q <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            shreg_q   <= 24'd0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef AUDIO_I2C_RETRY_EN
            retry_q   <= '0;
            word_q    <= 24'd0;
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shreg_q   <= shreg_d;
            nack_q    <= nack_d;
            err_q     <= err_d;
`ifdef AUDIO_I2C_RETRY_EN
            retry_q   <= retry_d;
            word_q    <= word_d;
            pend_q    <= pend_d;
`endif
        end
    end

    // Bus levels decoded from state and quarter; data bit is stable across all four quarters.
    always_comb begin
        o_scl    = 1'b1;
        o_sda_oe = 1'b0;
        case (state_q)
            S_START: o_sda_oe = quarter_q[1];
            S_BYTE: begin
                o_scl    = quarter_q[1];
                o_sda_oe = ~shreg_q[23];
            end
            S_ACK:   o_scl = quarter_q[1];
            S_STOP: begin
                o_scl    = (quarter_q != 2'd0);
                o_sda_oe = ~quarter_q[1];
            end
            default: ;
        endcase
    end

    assign o_i2c_idle      = (state_q == S_IDLE);
    assign o_i2c_ack_error = err_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_audio_controller_i2c.sv
// Testbench for audio_controller_i2c (QTR_DIV=2, MAX_RETRY=2).
// Honours AUDIO_I2C_RETRY_EN when the design is built with it.
module tb_audio_controller_i2c;

    localparam int Q         = 2;
    localparam int MAX_RETRY = 2;
`ifdef AUDIO_I2C_RETRY_EN
    localparam int ATTEMPTS  = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS  = 1;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] data = 24'd0;
    logic        write = 1'b0;
    logic [8:0]  plan = 9'd0;   // per attempt a, bits [3a+2:3a]: bit k = slave NACKs byte k
    logic        idle, ack_err, scl, sda_oe;
    logic        slave_low = 1'b0;
    logic        sda;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;
    assign sda = ~(sda_oe | slave_low);

    audio_controller_i2c #(.QTR_DIV(Q), .MAX_RETRY(MAX_RETRY)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_i2c_ctrl_data  (data),
        .i_i2c_ctrl_write (write),
        .o_i2c_idle       (idle),
        .o_i2c_ack_error  (ack_err),
        .o_scl            (scl),
        .o_sda_oe         (sda_oe),
        .i_sda            (sda),
        .o_dbg_state      (dbg_state)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] exp_q[$];        // per busy cycle: {idle, err, scl, oe}
    logic [7:0] exp_byte_q[$];   // bytes the slave must decode, in order
    logic [2:0] slave_plan_q[$]; // NACK mask handed to the slave per START
    int         exp_starts = 0, exp_stops = 0;
    logic       held_err = 1'b0;

    // kind: 0 START, 1 data bit, 2 ACK slot, 3 STOP
    task automatic push_phase(input int kind, input bit b, input bit err);
        logic scl_v, oe_v;
        for (int q = 0; q < 4; q++) begin
            case (kind)
                0:       begin scl_v = 1'b1;     oe_v = (q >= 2); end
                1:       begin scl_v = (q >= 2); oe_v = ~b;       end
                2:       begin scl_v = (q >= 2); oe_v = 1'b0;     end
                default: begin scl_v = (q != 0); oe_v = (q < 2);  end
            endcase
            repeat (Q) exp_q.push_back({1'b0, err, scl_v, oe_v});
        end
    endtask

    task automatic build_txn(input logic [23:0] w, input logic [8:0] p);
        bit err;
        bit done;
        bit nacked;
        logic [2:0] m;
        logic [7:0] by;
        err  = 1'b0;
        done = 1'b0;
        for (int a = 0; a < ATTEMPTS && !done; a++) begin
            m = p[3*a +: 3];
            nacked = 1'b0;
            slave_plan_q.push_back(m);
            exp_starts++;
            push_phase(0, 1'b0, err);
            for (int k = 0; k < 3 && !nacked; k++) begin
                by = w[23 - 8*k -: 8];
                exp_byte_q.push_back(by);
                for (int i = 7; i >= 0; i--) push_phase(1, by[i], err);
                push_phase(2, 1'b0, err);
                if (m[k]) nacked = 1'b1;
            end
            if (nacked && (a == ATTEMPTS - 1)) err = 1'b1;
            push_phase(3, 1'b0, err);
            exp_stops++;
            if (!nacked) done = 1'b1;
        end
    endtask

    // Per-cycle compare against the model; also decides acceptance of strobes.
    always @(negedge clk) begin
        logic [3:0] e;
        bit was_empty;
        if (reset) begin
            was_empty = (exp_q.size() == 0);
            if (was_empty) e = {1'b1, held_err, 1'b1, 1'b0};
            else begin
                e = exp_q.pop_front();
                held_err = e[2];
            end
            check("cycle{idle,err,scl,oe}", {28'd0, idle, ack_err, scl, sda_oe}, {28'd0, e});
            if (write && was_empty) begin
                build_txn(data, plan);
                held_err = 1'b0;
            end
        end
    end

    // Busy-length monitor.
    int run = 0, last_busy = 0;
    always @(negedge clk) begin
        if (!reset) run = 0;
        else if (!idle) run++;
        else if (run != 0) begin
            last_busy = run;
            run = 0;
        end
    end

    // ---------------- slave model ----------------
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         bitcnt = 0, byte_idx = 0, starts = 0, stops = 0;
    bit         in_ack = 1'b0;
    logic [7:0] sh = 8'd0;
    logic [2:0] cur_mask = 3'd0;

    always @(negedge clk) begin
        logic cs, cd;
        logic [7:0] eb;
        if (!reset) begin
            p_scl = 1'b1; p_sda = 1'b1; bitcnt = 0; in_ack = 1'b0; slave_low = 1'b0;
        end else begin
            cs = scl;
            cd = sda;
            if (p_scl && cs && p_sda && !cd) begin
                starts++;
                bitcnt = 0; in_ack = 1'b0; byte_idx = 0;
                cur_mask = (slave_plan_q.size() != 0) ? slave_plan_q.pop_front() : 3'd0;
            end else if (p_scl && cs && !p_sda && cd) begin
                stops++;
            end else if (!p_scl && cs) begin
                if (bitcnt < 8) begin
                    sh = {sh[6:0], cd};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (exp_byte_q.size() != 0) begin
                            eb = exp_byte_q.pop_front();
                            check("byte", {24'd0, sh}, {24'd0, eb});
                        end else begin
                            checks++;
                            $display("FAIL byte_extra: got %0h with no byte expected", sh);
                        end
                    end
                end else begin
                    in_ack = 1'b1;
                end
            end else if (p_scl && !cs) begin
                if (bitcnt == 8 && !in_ack) begin
                    slave_low = (byte_idx < 3) ? !cur_mask[byte_idx] : 1'b1;
                end else if (bitcnt == 8 && in_ack) begin
                    slave_low = 1'b0; bitcnt = 0; in_ack = 1'b0; byte_idx++;
                end
            end
            p_scl = cs;
            p_sda = cd;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe_now(input logic [23:0] w, input logic [8:0] p);
        data = w; plan = p; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] w, input logic [8:0] p);
        @(posedge clk); #1;
        strobe_now(w, p);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(idle && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL wait_done: still busy after %0d cycles", n);
        end
        #1;
    endtask

    function automatic logic [8:0] rand_plan();
        logic [8:0] p;
        p = 9'd0;
        for (int a = 0; a < 3; a++)
            if ($urandom_range(0, 3) == 0) p[3*a + $urandom_range(0, 2)] = 1'b1;
        return p;
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        #2;
        check("reset_scl", {31'd0, scl}, 32'd1);
        check("reset_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_err", {31'd0, ack_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Full write, slave ACKs everything.
        s0 = starts;
        strobe(24'h341E00, 9'd0);
        wait_done(2000);
        check("busy_full", last_busy, 32'd232);
        check("err_full", {31'd0, ack_err}, 32'd0);
        check("starts_full", starts - s0, 32'd1);

        // NACK on byte 0.
        s0 = starts;
`ifdef AUDIO_I2C_RETRY_EN
        strobe(24'h340C55, 9'b001_001_001);
        wait_done(2000);
        check("busy_nack0", last_busy, 32'd264);
        check("starts_nack0", starts - s0, 32'd3);
`else
        strobe(24'h340C55, 9'b000_000_001);
        wait_done(2000);
        check("busy_nack0", last_busy, 32'd88);
        check("starts_nack0", starts - s0, 32'd1);
`endif
        repeat (5) @(posedge clk);
        check("err_held", {31'd0, ack_err}, 32'd1);

        // Strobe while busy is dropped; accept clears the error.
        strobe(24'h341200, 9'd0);
        check("err_cleared", {31'd0, ack_err}, 32'd0);
        check("idle_drop", {31'd0, idle}, 32'd0);
        repeat (20) @(posedge clk);
        strobe(24'hFFFFFF, 9'd0);
        wait_done(2000);
        check("busy_drop", last_busy, 32'd232);
        check("bytes_left", exp_byte_q.size(), 32'd0);

        // Back-to-back: strobe on the first idle cycle.
        strobe(24'h1A2B3C, 9'd0);
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!idle && n < 2000);
            if (!idle) begin
                checks++;
                $display("FAIL b2b_wait: idle never returned");
            end
        end
        strobe_now(24'h5A0F81, 9'd0);
        check("b2b_idle_fell", {31'd0, idle}, 32'd0);
        wait_done(2000);

`ifdef AUDIO_I2C_RETRY_EN
        s0 = starts;
        strobe(24'h3456A5, 9'b000_010_010);
        wait_done(3000);
        check("retry_ok_starts", starts - s0, 32'd3);
        check("retry_ok_err", {31'd0, ack_err}, 32'd0);
        s0 = starts;
        strobe(24'h3401FF, 9'b111_111_111);
        wait_done(3000);
        check("retry_fail_starts", starts - s0, 32'd3);
        check("retry_fail_err", {31'd0, ack_err}, 32'd1);
`endif

        // Randomized traffic, with occasional strobes landing while busy.
        for (int t = 0; t < 20; t++) begin
            strobe(24'($urandom), rand_plan());
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 250)) @(posedge clk);
                strobe(24'($urandom), rand_plan());
            end
            wait_done(4000);
            repeat ($urandom_range(0, 10)) @(posedge clk);
        end
        check("starts_total", starts, exp_starts);
        check("stops_total", stops, exp_stops);

        // Reset during byte 1 aborts immediately.
        strobe(24'h34C3F0, 9'd0);
        repeat (100) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midreset_scl", {31'd0, scl}, 32'd1);
        check("midreset_oe", {31'd0, sda_oe}, 32'd0);
        check("midreset_idle", {31'd0, idle}, 32'd1);
        check("midreset_err", {31'd0, ack_err}, 32'd0);
        exp_q.delete();
        exp_byte_q.delete();
        slave_plan_q.delete();
        held_err = 1'b0;
        starts = 0; stops = 0; exp_starts = 0; exp_stops = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // One more transaction after the abort.
        strobe(24'h340A17, 9'b000_000_100);
        wait_done(3000);
        check("post_starts", starts, exp_starts);
        check("post_stops", stops, exp_stops);
        check("post_bytes_left", exp_byte_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
